// File: rtl/lenet_rx_pkg.sv
// lenet_rx_pkg: shared frame geometry, tag width and write-FSM encoding for the LeNet frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lenet_rx_pkg;

  localparam int DEF_FRAME_W  = 32;
  localparam int DEF_FRAME_H  = 32;
  localparam int DEF_PIX_BITS = 8;
  localparam int DEF_ADDR_W   = 10;
  localparam int FRAME_PIXELS = DEF_FRAME_W * DEF_FRAME_H;
  localparam int TAG_W        = 4;

  // IDLE waits for a frame start, FILL writes pixels, DISCARD swallows a frame that has no free bank.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_t;

endpackage

// File: rtl/lenet_rx_bank_ram.sv
// lenet_rx_bank_ram: simple dual-port frame RAM, one write port, one registered read port, address {bank,addr}.
// Latency: read data is registered, valid 1 cycle after i_raddr when i_re is high.
// Backpressure: none; i_re low holds o_rdat stable.
module lenet_rx_bank_ram #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_srst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat
);

  // Full power-of-two depth so {bank,addr} maps directly without an adder.
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdat;

  // Write port; contents are deliberately not reset so this maps to block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  // Registered read with synchronous clear of the output register only.
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      r_rdat <= '0;
    end else if (i_re) begin
      r_rdat <= r_mem[i_raddr];
    end
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/lenet_frame_rx.sv
// lenet_frame_rx: reassembles the per-pixel LeNet stream into a two-bank ping-pong frame buffer.
// Latency: frame presented the cycle after its last pixel write; rd_data 1 cycle after rd_addr.
// Backpressure: none on the stream (1 pixel/clk); a frame arriving with both banks full is dropped.
// Optional: define LENET_RX_STATS_EN to add saturating drop_cnt/short_cnt outputs.
module lenet_frame_rx
  import lenet_rx_pkg::*;
#(
  parameter int FRAME_W  = DEF_FRAME_W,
  parameter int FRAME_H  = DEF_FRAME_H,
  parameter int PIX_BITS = DEF_PIX_BITS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       srst_n,
  input  logic                       lenet_start,
  input  logic                       lenet_v,
  input  logic signed [PIX_BITS-1:0] lenet_pix,
  input  logic [TAG_W-1:0]           image_num,
  output logic                       frm_valid,
  output logic [TAG_W-1:0]           frm_tag,
  input  logic                       frm_release,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic signed [PIX_BITS-1:0] rd_data,
  output logic                       drop_pulse,
  output logic                       short_pulse
`ifdef LENET_RX_STATS_EN
  ,
  output logic [15:0]                drop_cnt,
  output logic [15:0]                short_cnt
`endif
);

  localparam int                NPIX      = FRAME_W * FRAME_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  wr_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt, w_waddr;
  logic              w_we, w_tag_we, w_done, w_drop, w_short;
  logic              w_start, w_rel;
  logic [1:0]        r_full, w_full_nxt;
  logic              r_wr_bank, r_rd_bank;
  logic              r_drop, r_short;
  logic [TAG_W-1:0]  r_tag [2];
  logic [PIX_BITS-1:0] w_rdat;

  assign w_start = lenet_start & lenet_v;
  // Release only counts when a frame is actually presented.
  assign w_rel   = frm_release & r_full[r_rd_bank];

  // Write FSM next-state: a start always rewinds to address 0; a full write bank diverts to DISCARD.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_waddr     = r_cnt;
    w_we        = 1'b0;
    w_tag_we    = 1'b0;
    w_done      = 1'b0;
    w_drop      = 1'b0;
    w_short     = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_start) begin
          // Early start: abandon the partial frame and refill the same bank.
          w_short   = 1'b1;
          w_we      = 1'b1;
          w_waddr   = '0;
          w_tag_we  = 1'b1;
          w_cnt_nxt = ADDR_W'(1);
        end else if (lenet_v) begin
          w_we = 1'b1;
          if (r_cnt == LAST_ADDR) begin
            w_done      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_IDLE, ST_DISCARD: begin
        // The full flag is the registered one, so a same-cycle release does not free the bank yet.
        if (w_start) begin
          if (r_full[r_wr_bank]) begin
            w_drop      = 1'b1;
            w_state_nxt = ST_DISCARD;
          end else begin
            w_we        = 1'b1;
            w_waddr     = '0;
            w_tag_we    = 1'b1;
            w_cnt_nxt   = ADDR_W'(1);
            w_state_nxt = ST_FILL;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Full flags: completion sets the write bank, release clears the read bank; they never collide.
  always_comb begin
    w_full_nxt = r_full;
    if (w_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rel)  w_full_nxt[r_rd_bank] = 1'b0;
  end

  // State register, bank pointers, latched tags and registered event pulses.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_tag[0]  <= '0;
      r_tag[1]  <= '0;
      r_drop    <= 1'b0;
      r_short   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= w_full_nxt;
      r_drop  <= w_drop;
      r_short <= w_short;
      if (w_tag_we) r_tag[r_wr_bank] <= image_num;
      if (w_done)   r_wr_bank <= ~r_wr_bank;
      if (w_rel)    r_rd_bank <= ~r_rd_bank;
    end
  end

  lenet_rx_bank_ram #(
    .AW (ADDR_W + 1),
    .DW (PIX_BITS)
  ) u_ram (
    .i_clk    (clk),
    .i_srst_n (srst_n),
    .i_we     (w_we),
    .i_waddr  ({r_wr_bank, w_waddr}),
    .i_wdat   (lenet_pix),
    .i_re     (r_full[r_rd_bank]),
    .i_raddr  ({r_rd_bank, rd_addr}),
    .o_rdat   (w_rdat)
  );

  assign frm_valid   = r_full[r_rd_bank];
  assign frm_tag     = r_tag[r_rd_bank];
  assign rd_data     = w_rdat;
  assign drop_pulse  = r_drop;
  assign short_pulse = r_short;

`ifdef LENET_RX_STATS_EN
  logic [15:0] r_drop_cnt, r_short_cnt;

  // Saturating event counters driven by the registered pulses.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_drop_cnt  <= '0;
      r_short_cnt <= '0;
    end else begin
      if (r_drop && (r_drop_cnt != 16'hFFFF))   r_drop_cnt  <= r_drop_cnt + 16'd1;
      if (r_short && (r_short_cnt != 16'hFFFF)) r_short_cnt <= r_short_cnt + 16'd1;
    end
  end

  assign drop_cnt  = r_drop_cnt;
  assign short_cnt = r_short_cnt;
`endif

endmodule

// File: tb/tb_lenet_frame_rx.sv
// tb_lenet_frame_rx: directed sequences, a readback vector table and randomized frames for lenet_frame_rx.
// The reference model tracks frames as a queue of {tag, seed}; pixel k of a frame is pixfn(seed, k).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_lenet_frame_rx;

  logic              clk = 1'b0;
  logic              srst_n;
  logic              lenet_start;
  logic              lenet_v;
  logic signed [7:0] lenet_pix;
  logic [3:0]        image_num;
  logic              frm_valid;
  logic [3:0]        frm_tag;
  logic              frm_release;
  logic [9:0]        rd_addr;
  logic signed [7:0] rd_data;
  logic              drop_pulse;
  logic              short_pulse;
`ifdef LENET_RX_STATS_EN
  logic [15:0]       drop_cnt;
  logic [15:0]       short_cnt;
`endif

  always #5 clk = ~clk;

  lenet_frame_rx dut (
    .clk         (clk),
    .srst_n      (srst_n),
    .lenet_start (lenet_start),
    .lenet_v     (lenet_v),
    .lenet_pix   (lenet_pix),
    .image_num   (image_num),
    .frm_valid   (frm_valid),
    .frm_tag     (frm_tag),
    .frm_release (frm_release),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .drop_pulse  (drop_pulse),
    .short_pulse (short_pulse)
`ifdef LENET_RX_STATS_EN
    ,
    .drop_cnt    (drop_cnt),
    .short_cnt   (short_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] seed;
  } frm_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  int errors = 0;
  int checks = 0;

  // reference model state
  frm_t       mq[$];
  bit         m_fill;
  int         m_cnt;
  logic [3:0] m_tag;
  logic [7:0] m_seed;
  logic [7:0] exp_rd;
  int         m_drops, m_shorts;
  int         n_drop_obs, n_short_obs;

  function automatic logic [7:0] pixfn(input logic [7:0] seed, input int idx);
    int t;
    if (seed == 8'd0) t = idx;
    else              t = int'(seed) * 29 + idx * 7 + (idx >>> 5);
    return t[7:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model by the spec's rules, then compare.
  task automatic step(input bit rst_n, input bit s, input bit v, input logic [7:0] seed, input int idx,
                      input logic [3:0] tag, input bit rel, input logic [9:0] addr);
    bit e_drop, e_short, pre_valid, rel_ok;
    srst_n      = rst_n;
    lenet_start = s;
    lenet_v     = v;
    lenet_pix   = pixfn(seed, idx);
    image_num   = tag;
    frm_release = rel;
    rd_addr     = addr;
    e_drop  = 1'b0;
    e_short = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_fill = 1'b0;
      m_cnt  = 0;
      exp_rd = 8'h00;
    end else begin
      pre_valid = (mq.size() > 0);
      if (pre_valid) exp_rd = pixfn(mq[0].seed, int'(addr));
      rel_ok = rel && pre_valid;
      if (s && v) begin
        if (m_fill) begin
          e_short = 1'b1;
          m_tag = tag; m_seed = seed; m_cnt = 1;
        end else if (mq.size() == 2) begin
          e_drop = 1'b1;
        end else begin
          m_fill = 1'b1;
          m_tag = tag; m_seed = seed; m_cnt = 1;
        end
      end else if (v && m_fill) begin
        m_cnt++;
      end
      if (m_fill && m_cnt == 1024) begin
        mq.push_back('{tag: m_tag, seed: m_seed});
        m_fill = 1'b0;
      end
      if (rel_ok) void'(mq.pop_front());
    end
    m_drops  += int'(e_drop);
    m_shorts += int'(e_short);
    @(posedge clk);
    #1;
    n_drop_obs  += (drop_pulse === 1'b1) ? 1 : 0;
    n_short_obs += (short_pulse === 1'b1) ? 1 : 0;
    chk("frm_valid", 16'(frm_valid), 16'(mq.size() > 0));
    if (mq.size() > 0) chk("frm_tag", 16'(frm_tag), 16'(mq[0].tag));
    if (!rst_n) chk("frm_tag_reset", 16'(frm_tag), 16'h0);
    chk("rd_data", 16'($unsigned(rd_data)), 16'(exp_rd));
    chk("drop_pulse", 16'(drop_pulse), 16'(e_drop));
    chk("short_pulse", 16'(short_pulse), 16'(e_short));
  endtask

  task automatic send_frame(input logic [7:0] seed, input logic [3:0] tag, input int npix,
                            input int gap_pct, input int rel_pm);
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(0, 99) < gap_pct)
        step(1, 0, 0, seed, i, tag, $urandom_range(0, 999) < rel_pm, 10'($urandom_range(0, 1023)));
      step(1, i == 0, 1, seed, i, tag, $urandom_range(0, 999) < rel_pm, 10'($urandom_range(0, 1023)));
    end
  endtask

  // Idle cycles; stray valids are only offered while no frame is being filled.
  task automatic idle(input int n, input bit stray, input int rel_pm);
    for (int i = 0; i < n; i++)
      step(1, 0, stray && !m_fill && ($urandom_range(0, 1) == 1), 8'h5A, i, 4'hF,
           $urandom_range(0, 999) < rel_pm, 10'($urandom_range(0, 1023)));
  endtask

  task automatic release_frm();
    step(1, 0, 0, 8'h00, 0, 4'h0, 1, 10'($urandom_range(0, 1023)));
  endtask

  task automatic read_at(input logic [9:0] a);
    step(1, 0, 0, 8'h00, 0, 4'h0, 0, a);
  endtask

  initial begin
    rd_vec_t tbl[7];
    int d0, s0;
    tbl[0] = '{addr: 10'd0,    exp: 8'h00};
    tbl[1] = '{addr: 10'd1,    exp: 8'h01};
    tbl[2] = '{addr: 10'd255,  exp: 8'hFF};
    tbl[3] = '{addr: 10'd256,  exp: 8'h00};
    tbl[4] = '{addr: 10'd700,  exp: 8'hBC};
    tbl[5] = '{addr: 10'd1022, exp: 8'hFE};
    tbl[6] = '{addr: 10'd1023, exp: 8'hFF};
    m_drops = 0; m_shorts = 0; n_drop_obs = 0; n_short_obs = 0;
    m_fill = 1'b0; m_cnt = 0; m_tag = 4'h0; m_seed = 8'h00; exp_rd = 8'h00;

    // reset: all outputs zero
    step(0, 0, 0, 8'h00, 0, 4'h0, 0, 10'd0);
    step(0, 1, 1, 8'h00, 0, 4'h3, 1, 10'd5);

    // stray valid and release with nothing presented
    for (int i = 0; i < 8; i++) step(1, 0, 1, 8'h11, i, 4'h2, i[0], 10'(i));
    chk("stray_no_pulse", 16'(n_drop_obs + n_short_obs), 16'd0);

    // single frame, pixel = i mod 256, tag 5
    send_frame(8'h00, 4'd5, 1024, 0, 0);
    chk("single_valid", 16'(frm_valid), 16'd1);
    chk("single_tag", 16'(frm_tag), 16'd5);
    for (int i = 0; i < 7; i++) begin
      read_at(tbl[i].addr);
      chk("tbl_rd_data", 16'($unsigned(rd_data)), 16'(tbl[i].exp));
    end
    idle(5, 1, 0);
    release_frm();
    chk("single_released", 16'(frm_valid), 16'd0);
    release_frm();

    // back-to-back frames, zero gap
    d0 = n_drop_obs;
    send_frame(8'd11, 4'd1, 1024, 0, 0);
    send_frame(8'd22, 4'd2, 1024, 0, 0);
    chk("b2b_tag1", 16'(frm_tag), 16'd1);
    release_frm();
    chk("b2b_valid_kept", 16'(frm_valid), 16'd1);
    chk("b2b_tag2", 16'(frm_tag), 16'd2);
    chk("b2b_no_drop", 16'(n_drop_obs - d0), 16'd0);
    release_frm();

    // overflow: third frame without release is dropped once
    d0 = n_drop_obs;
    send_frame(8'd31, 4'd1, 1024, 0, 0);
    send_frame(8'd32, 4'd2, 1024, 0, 0);
    send_frame(8'd33, 4'd3, 1024, 0, 0);
    chk("ovf_one_drop", 16'(n_drop_obs - d0), 16'd1);
    chk("ovf_tag1", 16'(frm_tag), 16'd1);
    read_at(10'd1023);
    release_frm();
    chk("ovf_tag2", 16'(frm_tag), 16'd2);
    read_at(10'd0);
    release_frm();
    chk("ovf_third_absent", 16'(frm_valid), 16'd0);

    // short frame then full frame tag 7
    s0 = n_short_obs;
    send_frame(8'd44, 4'd3, 500, 0, 0);
    send_frame(8'd55, 4'd7, 1024, 0, 0);
    chk("short_once", 16'(n_short_obs - s0), 16'd1);
    chk("short_tag7", 16'(frm_tag), 16'd7);
    read_at(10'd0);
    chk("short_rd0", 16'($unsigned(rd_data)), 16'(pixfn(8'd55, 0)));
    read_at(10'd1023);
    chk("short_rd1023", 16'($unsigned(rd_data)), 16'(pixfn(8'd55, 1023)));
    release_frm();

    // reset in the middle of a fill
    send_frame(8'd66, 4'd4, 300, 0, 0);
    step(0, 0, 1, 8'd66, 300, 4'd4, 0, 10'd0);
    chk("mid_rst_valid", 16'(frm_valid), 16'd0);
    chk("mid_rst_rd", 16'($unsigned(rd_data)), 16'd0);
    send_frame(8'd77, 4'd9, 1024, 5, 0);
    chk("post_rst_tag", 16'(frm_tag), 16'd9);
    read_at(10'd777);
    release_frm();

    // randomized frames: gaps, partial frames, stray valids, random releases
    for (int f = 0; f < 10; f++) begin
      int np;
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1023) : 1024;
      send_frame(8'($urandom_range(1, 255)), 4'($urandom_range(0, 15)), np, 10, 3);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 20), 1, 3);
    end
    for (int i = 0; i < 3; i++) release_frm();

    chk("drop_total", 16'(n_drop_obs), 16'(m_drops));
    chk("short_total", 16'(n_short_obs), 16'(m_shorts));
`ifdef LENET_RX_STATS_EN
    chk("drop_cnt", drop_cnt, 16'(m_drops));
    chk("short_cnt", short_cnt, 16'(m_shorts));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lenet_frame_rx.md
Name: lenet_frame_rx

Overview:
- Receiver end of the per-pixel LeNet input stream (start pulse, per-pixel valid, signed 8-bit pixel, 4-bit image tag).
- Reassembles each 32x32 padded frame into a ping-pong on-chip buffer.
- Hands complete frames to the LeNet engine through a valid/release handshake and a 1-cycle-latency random-read port.
- Sits between the pixel pre-processing stream and the conv1 layer input.

Parameters:
- FRAME_W, 32, pixels per line
- FRAME_H, 32, lines per frame
- PIX_BITS, 8, signed pixel width
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= FRAME_W*FRAME_H

Ports:
- clk  in  1  system clock (100 MHz)
- srst_n  in  1  synchronous reset, active-low
- lenet_start  in  1  1-clk pulse marking the first pixel of a frame; coincident with that pixel's lenet_v
- lenet_v  in  1  per-pixel valid
- lenet_pix  in  PIX_BITS  signed pixel, raster order
- image_num  in  4  image tag, sampled on an accepted lenet_start
- frm_valid  out  1  a complete frame is available to the consumer
- frm_tag  out  4  image tag of the presented frame
- frm_release  in  1  consumer done with the presented frame; 1-clk pulse
- rd_addr  in  ADDR_W  read address, row*FRAME_W+col
- rd_data  out  PIX_BITS  signed, registered, 1 cycle after rd_addr
- drop_pulse  out  1  1-clk pulse when an incoming frame is discarded
- short_pulse  out  1  1-clk pulse when a frame is aborted by an early lenet_start

Behaviour:
- Reset (srst_n=0 on a clk edge):
  - frm_valid=0, frm_tag=0, rd_data=0, drop_pulse=0, short_pulse=0.
  - Both banks marked empty; write FSM to IDLE; write count=0; read bank pointer=0.
  - Buffer RAM contents are not cleared.
- Two banks of FRAME_W*FRAME_H entries; each bank has a full flag.
- Write FSM states: IDLE, FILL, DISCARD.
- IDLE:
  - lenet_v without lenet_start is ignored.
  - lenet_start&lenet_v with the write bank empty: write pixel at addr 0, latch tag, count=1, go to FILL.
  - lenet_start&lenet_v with the write bank full: drop_pulse=1, go to DISCARD.
- FILL:
  - Each lenet_v writes lenet_pix at address count, then count++.
  - The write that makes count reach FRAME_W*FRAME_H sets the bank full and returns to IDLE; the write bank pointer toggles on the same edge.
  - lenet_start&lenet_v before completion: short_pulse=1. The partial frame is abandoned and the same bank restarts at addr 0 with the new pixel and new tag.
- DISCARD:
  - Pixels are consumed and not written.
  - A later lenet_start re-evaluates as in IDLE, including generating a new drop_pulse if the bank is still full.
- Read side:
  - frm_valid=1 whenever the read bank is full; frm_tag is that bank's latched tag.
  - rd_data is the read-bank entry at rd_addr, registered, 1-cycle latency.
  - When frm_valid=0, rd_data is don't-care but stable.
  - frm_release while frm_valid=1 clears the read-bank full flag and toggles the read pointer. frm_valid falls the next cycle, or stays 1 if the other bank is already full.
  - frm_release while frm_valid=0 is ignored.
- Simultaneous events:
  - Release and frame completion in the same cycle are both honoured; the full flags are independent per bank.
  - A release frees the bank for a lenet_start arriving the next cycle, not the same cycle.
  - Overrun: lenet_v beyond FRAME_W*FRAME_H cannot occur in FILL (the FSM exits); in IDLE it is ignored.
- Throughput: accepts one pixel per clk back-to-back. Frame-to-frame gap may be 0 cycles.

Optional Feature:
- LENET_RX_STATS_EN defined:
  - Adds outputs drop_cnt[15:0] and short_cnt[15:0].
  - Each saturates at 0xFFFF and increments on the respective pulse.
  - Both clear on reset.
- Undefined: the ports and counters are absent; the pulses remain.

Decomposition:
- Package lenet_rx_pkg holds FRAME_PIXELS = FRAME_W*FRAME_H, the write FSM state encoding (IDLE/FILL/DISCARD), and the tag width (4).
- One sub-module, lenet_rx_bank_ram: simple dual-port RAM, one write port and one registered read port, depth 2*FRAME_PIXELS, address {bank,addr}. It is inferred as BRAM.

Test Plan:
- Single frame: reset, one frame of pixels value (i mod 256) with tag 5 -> frm_valid rises 1 cycle after the 1024th write. frm_tag=5. Reading rd_addr=0/1023 returns 0/0xFF (-1) one cycle later.
- Back-to-back: two frames with tags 1 and 2, gap 0 -> frm_valid stays 1. frm_tag=1; after release it becomes 2 with no drop_pulse.
- Overflow: three frames with no release -> the third raises exactly one drop_pulse. Tags remain 1 then 2; the third frame's pixels never appear.
- Short frame: lenet_start at pixel 500 of a frame -> short_pulse=1 once. The following full frame (tag 7) is presented with correct data at addr 0 and 1023.
- Reset mid-fill: srst_n=0 at pixel 300 -> all outputs 0. A subsequent complete frame is received normally.
- Stray input: lenet_v without a prior lenet_start, and frm_release with frm_valid=0 -> no state change, no pulses. With LENET_RX_STATS_EN, drop_cnt preloaded to 0xFFFF stays 0xFFFF after another drop.
